// File: rtl/prog_loader_if.sv
// Memory-port and pipe-in FIFO signals shared by the loader, the core flash port and the rom.
interface prog_loader_if;
  // Pipe-in FIFO read side (first-word-fall-through)
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd;

  // Core flash request and returned read data
  logic        cpu_men;
  logic [31:0] cpu_maddr;
  logic [31:0] cpu_mdin;
  logic [3:0]  cpu_mwe;
  logic [31:0] cpu_mdout;

  // Instruction memory port
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_we;
  logic [31:0] mem_dout;

  // The loader side
  modport master (
    input  fifo_dout, fifo_empty,
    input  cpu_men, cpu_maddr, cpu_mdin, cpu_mwe,
    input  mem_dout,
    output fifo_rd, cpu_mdout,
    output mem_en, mem_addr, mem_din, mem_we
  );

  // The FIFO, core and memory side
  modport slave (
    output fifo_dout, fifo_empty,
    output cpu_men, cpu_maddr, cpu_mdin, cpu_mwe,
    output mem_dout,
    input  fifo_rd, cpu_mdout,
    input  mem_en, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/prog_loader_ctrl.sv
// Host programming sequencer for the instruction memory: loads words from the pipe-in
// FIFO, reads them back against a running checksum, and arbitrates the memory port
// between the core flash interface and the loader.
module prog_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          prog_en,
  input  logic [31:0]   word_count,
  prog_loader_if.master bus,
  output logic          cpu_resetn,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err_code,
  output logic [31:0]   words_written,
  output logic [31:0]   checksum
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] MAX_N = DW'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_SIZE   = 2'd1;
  localparam logic [1:0] ERR_VERIFY = 2'd2;
  localparam logic [1:0] ERR_ABORT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_VERIFY, S_CHECK, S_DONE
  } state_t;

  state_t        state;
  logic          prog_en_q;
  logic [DW-1:0] n_q;
  logic [DW-1:0] rd_idx;
  logic [DW-1:0] rsum;

  // Loader-side memory request, presented one cycle after it is decided
  logic          ld_en;
  logic [DW-1:0] ld_addr;
  logic [DW-1:0] ld_din;
  logic [3:0]    ld_we;

  logic          prog_rise;
  logic          in_busy;
  logic          pop;
  logic [DW-1:0] wr_addr;
  logic [DW-1:0] rd_next;
  logic [DW-1:0] rd_next_addr;
  logic [DW-1:0] rsum_fin;

  // Decode helpers: edge detect, pop condition and address arithmetic
  always_comb begin
    prog_rise    = prog_en && !prog_en_q;
    in_busy      = (state == S_LOAD) || (state == S_DRAIN) ||
                   (state == S_VERIFY) || (state == S_CHECK);
    // An abort cycle pops nothing so words_written stays at the count already written
    pop          = (state == S_LOAD) && prog_en && !bus.fifo_empty && (words_written < n_q);
    wr_addr      = BASE_ADDR + {words_written[DW-3:0], 2'b00};
    rd_next      = rd_idx + DW'(1);
    rd_next_addr = BASE_ADDR + {rd_next[DW-3:0], 2'b00};
    rsum_fin     = rsum + bus.mem_dout;
  end

  // Memory port mux: the core owns the port only while idle
  always_comb begin
    bus.fifo_rd   = pop;
    bus.cpu_mdout = bus.mem_dout;
    if (state == S_IDLE) begin
      bus.mem_en   = bus.cpu_men;
      bus.mem_addr = bus.cpu_maddr;
      bus.mem_din  = bus.cpu_mdin;
      bus.mem_we   = bus.cpu_mwe;
    end else begin
      bus.mem_en   = ld_en;
      bus.mem_addr = ld_addr;
      bus.mem_din  = ld_din;
      bus.mem_we   = ld_we;
    end
  end

  // Sequencer state, loader memory request and status registers
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state         <= S_IDLE;
      prog_en_q     <= 1'b0;
      n_q           <= '0;
      rd_idx        <= '0;
      rsum          <= '0;
      ld_en         <= 1'b0;
      ld_addr       <= '0;
      ld_din        <= '0;
      ld_we         <= '0;
      cpu_resetn    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_code      <= ERR_NONE;
      words_written <= '0;
      checksum      <= '0;
    end else begin
      prog_en_q <= prog_en;
      if (in_busy && !prog_en) begin
        // Host withdrew mid-load: release the core, keep the progress counters
        state      <= S_IDLE;
        ld_en      <= 1'b0;
        ld_we      <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
        cpu_resetn <= 1'b1;
        err_code   <= ERR_ABORT;
      end else begin
        case (state)
          S_IDLE: begin
            ld_en <= 1'b0;
            ld_we <= '0;
            if (prog_rise) begin
              n_q           <= word_count;
              words_written <= '0;
              checksum      <= '0;
              err_code      <= ERR_NONE;
              cpu_resetn    <= 1'b0;
              if (word_count > MAX_N) begin
                err_code <= ERR_SIZE;
                done     <= 1'b1;
                state    <= S_DONE;
              end else if (word_count == '0) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                busy  <= 1'b1;
                state <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            ld_en <= pop;
            ld_we <= pop ? 4'hF : 4'h0;
            if (pop) begin
              ld_addr       <= wr_addr;
              ld_din        <= bus.fifo_dout;
              checksum      <= checksum + bus.fifo_dout;
              words_written <= words_written + DW'(1);
              if (words_written + DW'(1) == n_q) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            // Final write is on the port now; queue the first readback
            ld_en   <= 1'b1;
            ld_we   <= '0;
            ld_addr <= BASE_ADDR;
            rd_idx  <= '0;
            rsum    <= '0;
            state   <= S_VERIFY;
          end
          S_VERIFY: begin
            // Data on mem_dout belongs to the read issued in the previous cycle
            if (rd_idx != '0) rsum <= rsum_fin;
            if (rd_next == n_q) begin
              ld_en <= 1'b0;
              state <= S_CHECK;
            end else begin
              rd_idx  <= rd_next;
              ld_addr <= rd_next_addr;
            end
          end
          S_CHECK: begin
            if (rsum_fin != checksum) err_code <= ERR_VERIFY;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE: begin
            if (!prog_en) begin
              done       <= 1'b0;
              cpu_resetn <= 1'b1;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: FIFO and memory models, write scoreboard, table of loads
// plus hand sequences for starvation, abort, passthrough and reset.
module tb_prog_loader_ctrl;

  localparam int unsigned MAXW = 16384;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        prog_en;
  logic [31:0] word_count;
  logic        cpu_resetn;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] words_written;
  logic [31:0] checksum;

  prog_loader_if bus ();

  prog_loader_ctrl #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAXW)) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .prog_en       (prog_en),
    .word_count    (word_count),
    .bus           (bus),
    .cpu_resetn    (cpu_resetn),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .words_written (words_written),
    .checksum      (checksum)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // First-word-fall-through FIFO model
  logic [31:0] fifo_mem [256];
  logic [7:0]  fifo_wp = 8'd0;
  logic [7:0]  fifo_rp = 8'd0;
  logic        fifo_flush = 1'b0;
  assign bus.fifo_empty = (fifo_wp == fifo_rp);
  assign bus.fifo_dout  = fifo_mem[fifo_rp];
  always @(posedge CLK) begin
    if (fifo_flush) fifo_rp <= fifo_wp;
    else if (bus.fifo_rd) fifo_rp <= fifo_rp + 8'd1;
  end

  // Single-port memory, 1-cycle read latency, optional +1 corruption on one word
  logic [31:0] mem [MAXW];
  logic [31:0] mem_q = 32'd0;
  int          corrupt_k = -1;
  assign bus.mem_dout = mem_q;
  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we != 4'h0) mem[bus.mem_addr[15:2]] <= bus.mem_din;
      else mem_q <= mem[bus.mem_addr[15:2]] +
                    ((corrupt_k >= 0 && 32'(corrupt_k) == {18'd0, bus.mem_addr[15:2]}) ? 32'd1 : 32'd0);
    end
  end

  // Output monitor: records loader writes, memory activity and pops
  logic [31:0] obs_addr [256];
  logic [31:0] obs_data [256];
  int          obs_cyc  [256];
  int wr_cnt = 0;
  int men_cnt = 0;
  int bad_pops = 0;
  int last_pop_cyc = 0;
  always @(negedge CLK) begin
    if (bus.mem_en) men_cnt <= men_cnt + 1;
    if (bus.mem_en && bus.mem_we != 4'h0 && busy) begin
      obs_addr[wr_cnt[7:0]] <= bus.mem_addr;
      obs_data[wr_cnt[7:0]] <= bus.mem_din;
      obs_cyc[wr_cnt[7:0]]  <= cyc;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.fifo_rd) begin
      last_pop_cyc <= cyc;
      if (bus.fifo_empty) bad_pops <= bad_pops + 1;
    end
  end

  // Scoreboard of expected memory writes
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q [$];

  typedef struct {
    string       name;
    logic [31:0] n;
    int unsigned extra;
    bit          use_tbl;
    logic [3:0][31:0] words;
    int          corrupt;
    logic [1:0]  exp_err;
    bit          chk_lat;
  } vec_t;
  vec_t vecs [6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_fifo(input logic [31:0] w);
    fifo_mem[fifo_wp] = w;
    fifo_wp = fifo_wp + 8'd1;
  endtask

  task automatic flush_fifo();
    fifo_flush = 1'b1;
    step();
    fifo_flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    for (int i = 0; i < 400 && !done; i++) step();
    dcyc = cyc;
    chk({tag, ":done"}, 32'(done), 32'd1);
  endtask

  task automatic check_writes(input int base, input int n_exp, input string tag);
    wr_t e;
    chk({tag, ":wr_count"}, 32'(wr_cnt - base), 32'(n_exp));
    for (int i = base; i < wr_cnt; i++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk({tag, ":wr_addr"}, obs_addr[i[7:0]], e.addr);
        chk({tag, ":wr_data"}, obs_data[i[7:0]], e.data);
      end
    end
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int          base_w, base_m, nsup, nwr, dcyc;
    logic [31:0] w, mcks;
    bit          ovs;
    ovs    = (v.n > 32'(MAXW));
    nwr    = ovs ? 0 : int'(v.n);
    nsup   = nwr + int'(v.extra);
    base_w = wr_cnt;
    base_m = men_cnt;
    mcks   = 32'd0;
    corrupt_k = v.corrupt;
    for (int i = 0; i < nsup; i++) begin
      if (v.use_tbl && i < 4) w = v.words[i];
      else w = $urandom;
      push_fifo(w);
      if (i < nwr) begin
        exp_q.push_back('{addr: 32'(i * 4), data: w});
        mcks = mcks + w;
      end
    end
    word_count = v.n;
    prog_en    = 1'b1;
    step();
    chk({v.name, ":cpu_resetn_lo"}, 32'(cpu_resetn), 32'd0);
    wait_done(v.name, dcyc);
    chk({v.name, ":err_code"}, 32'(err_code), 32'(v.exp_err));
    chk({v.name, ":words_written"}, words_written, 32'(nwr));
    chk({v.name, ":checksum"}, checksum, mcks);
    chk({v.name, ":busy"}, 32'(busy), 32'd0);
    chk({v.name, ":cpu_resetn_held"}, 32'(cpu_resetn), 32'd0);
    check_writes(base_w, nwr, v.name);
    chk({v.name, ":mem_cycles"}, 32'(men_cnt - base_m), 32'(2 * nwr));
    chk({v.name, ":fifo_left"}, 32'(8'(fifo_wp - fifo_rp)), 32'(v.extra));
    if (v.chk_lat) begin
      chk({v.name, ":checksum_const"}, checksum, 32'h0000_0005);
      chk({v.name, ":done_latency"}, 32'(dcyc - last_pop_cyc), 32'd7);
      chk({v.name, ":wr_span"}, 32'(obs_cyc[(base_w + 3) & 255] - obs_cyc[base_w & 255]), 32'd3);
    end
    prog_en = 1'b0;
    step();
    chk({v.name, ":release_resetn"}, 32'(cpu_resetn), 32'd1);
    chk({v.name, ":release_done"}, 32'(done), 32'd0);
    chk({v.name, ":err_hold"}, 32'(err_code), 32'(v.exp_err));
    chk({v.name, ":ww_hold"}, words_written, 32'(nwr));
    corrupt_k = -1;
    flush_fifo();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int          base_w, base_p, dcyc;
    logic [31:0] w [4];
    logic [31:0] mcks;

    RESETn        = 1'b0;
    prog_en       = 1'b0;
    word_count    = 32'd0;
    bus.cpu_men   = 1'b0;
    bus.cpu_maddr = 32'd0;
    bus.cpu_mdin  = 32'd0;
    bus.cpu_mwe   = 4'h0;
    repeat (3) step();

    chk("rst:cpu_resetn", 32'(cpu_resetn), 32'd1);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:err_code", 32'(err_code), 32'd0);
    chk("rst:words_written", words_written, 32'd0);
    chk("rst:checksum", checksum, 32'd0);
    chk("rst:fifo_rd", 32'(bus.fifo_rd), 32'd0);
    chk("rst:mem_en", 32'(bus.mem_en), 32'd0);
    RESETn = 1'b1;
    step();

    vecs[0] = '{name: "load4", n: 32'd4, extra: 0, use_tbl: 1'b1,
                words: {32'hFFFF_FFFF, 32'h3, 32'h2, 32'h1}, corrupt: -1, exp_err: 2'd0, chk_lat: 1'b1};
    vecs[1] = '{name: "one_word", n: 32'd1, extra: 2, use_tbl: 1'b1,
                words: {32'h0, 32'h0, 32'h0, 32'hA5A5_0001}, corrupt: -1, exp_err: 2'd0, chk_lat: 1'b0};
    vecs[2] = '{name: "oversize", n: 32'd16385, extra: 1, use_tbl: 1'b0,
                words: '0, corrupt: -1, exp_err: 2'd1, chk_lat: 1'b0};
    vecs[3] = '{name: "zero", n: 32'd0, extra: 1, use_tbl: 1'b0,
                words: '0, corrupt: -1, exp_err: 2'd0, chk_lat: 1'b0};
    vecs[4] = '{name: "rand6", n: 32'd6, extra: 0, use_tbl: 1'b0,
                words: '0, corrupt: -1, exp_err: 2'd0, chk_lat: 1'b0};
    vecs[5] = '{name: "corrupt", n: 32'd4, extra: 0, use_tbl: 1'b0,
                words: '0, corrupt: 2, exp_err: 2'd2, chk_lat: 1'b0};

    foreach (vecs[i]) run_vec(vecs[i]);

    // Starved FIFO: words trickle in at cycles 2, 9 and 20, plus one surplus word
    base_w = wr_cnt;
    base_p = bad_pops;
    mcks   = 32'd0;
    foreach (w[i]) w[i] = $urandom;
    word_count = 32'd3;
    prog_en    = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 2 || c == 9 || c == 20) begin
        push_fifo(w[(c == 2) ? 0 : (c == 9) ? 1 : 2]);
        exp_q.push_back('{addr: 32'((c == 2) ? 0 : (c == 9) ? 4 : 8), data: w[(c == 2) ? 0 : (c == 9) ? 1 : 2]});
        mcks = mcks + w[(c == 2) ? 0 : (c == 9) ? 1 : 2];
      end
      if (c == 20) push_fifo(w[3]);
    end
    wait_done("starved", dcyc);
    chk("starved:words_written", words_written, 32'd3);
    chk("starved:checksum", checksum, mcks);
    chk("starved:err_code", 32'(err_code), 32'd0);
    check_writes(base_w, 3, "starved");
    chk("starved:bad_pops", 32'(bad_pops - base_p), 32'd0);
    chk("starved:fifo_left", 32'(8'(fifo_wp - fifo_rp)), 32'd1);
    prog_en = 1'b0;
    step();
    flush_fifo();

    // Abort after 2 of 8 words, then the core gets the port back
    base_w = wr_cnt;
    for (int i = 0; i < 2; i++) begin
      w[i] = $urandom;
      push_fifo(w[i]);
      exp_q.push_back('{addr: 32'(i * 4), data: w[i]});
    end
    word_count = 32'd8;
    prog_en    = 1'b1;
    for (int i = 0; i < 40 && words_written != 32'd2; i++) step();
    chk("abort:two_loaded", words_written, 32'd2);
    step();
    step();
    prog_en = 1'b0;
    step();
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:err_code", 32'(err_code), 32'd3);
    chk("abort:words_written", words_written, 32'd2);
    chk("abort:cpu_resetn", 32'(cpu_resetn), 32'd1);
    chk("abort:done", 32'(done), 32'd0);
    check_writes(base_w, 2, "abort");

    // IDLE passthrough is combinational
    bus.cpu_maddr = 32'h0000_0040;
    bus.cpu_men   = 1'b1;
    #1;
    chk("pass:mem_addr", bus.mem_addr, 32'h0000_0040);
    chk("pass:mem_en", 32'(bus.mem_en), 32'd1);
    step();
    chk("pass:cpu_mdout", bus.cpu_mdout, mem_q);
    bus.cpu_men = 1'b0;
    step();

    // Reset asserted while reading back
    base_w = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      mcks = $urandom;
      push_fifo(mcks);
      exp_q.push_back('{addr: 32'(i * 4), data: mcks});
    end
    word_count = 32'd8;
    prog_en    = 1'b1;
    for (int i = 0; i < 60 && !(busy && bus.mem_en && bus.mem_we == 4'h0); i++) step();
    chk("rstv:in_verify", 32'(busy && bus.mem_en && bus.mem_we == 4'h0), 32'd1);
    step();
    RESETn  = 1'b0;
    prog_en = 1'b0;
    step();
    chk("rstv:cpu_resetn", 32'(cpu_resetn), 32'd1);
    chk("rstv:busy", 32'(busy), 32'd0);
    chk("rstv:done", 32'(done), 32'd0);
    chk("rstv:err_code", 32'(err_code), 32'd0);
    chk("rstv:words_written", words_written, 32'd0);
    chk("rstv:checksum", checksum, 32'd0);
    chk("rstv:mem_en", 32'(bus.mem_en), 32'd0);
    chk("rstv:fifo_rd", 32'(bus.fifo_rd), 32'd0);
    RESETn = 1'b1;
    step();
    check_writes(base_w, 8, "rstv");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
# prog_loader_ctrl

Sequences host-driven programming of the instruction memory and arbitrates its single port between the Cortex-M core's flash interface and the loader. Words arrive from the host pipe-in FIFO. Each word is written to consecutive word addresses, then read back and checked against a running checksum. The core is held in reset from load start until the host drops `prog_en`. Sits between the pipe-in FIFO, the `rom` instance and the `Top` flash port, replacing the ad-hoc programming mux and address counter.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the first programmed word; word-aligned.
- `MAX_WORDS`, 16384: memory depth in 32-bit words.

Ports:
- `CLK` in 1: single clock. Core clock domain; the FIFO read side is on this clock.
- `RESETn` in 1: reset, synchronous, active-low.
- `prog_en` in 1: host programming request, level; already synchronised to `CLK`.
- `word_count` in 32: number of words to load; sampled on the `prog_en` rising edge.
- `fifo_dout` in 32: first-word-fall-through FIFO data; valid while `fifo_empty`=0.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd` out 1: FIFO pop; combinational.
- `cpu_men` in 1, `cpu_maddr` in 32, `cpu_mdin` in 32, `cpu_mwe` in 4: core flash request.
- `cpu_mdout` out 32: read data returned to the core; always equals `mem_dout`.
- `mem_en` out 1, `mem_addr` out 32, `mem_din` out 32, `mem_we` out 4: memory port.
- `mem_dout` in 32: memory read data; 1-cycle read latency.
- `cpu_resetn` out 1: core reset, active-low.
- `busy` out 1: high in LOAD, DRAIN, VERIFY and CHECK.
- `done` out 1: high in DONE.
- `err_code` out 2: error status.
  - 0 = none
  - 1 = size (`word_count` > `MAX_WORDS`)
  - 2 = verify mismatch
  - 3 = aborted
- `words_written` out 32: count of words written in the current or last load.
- `checksum` out 32: mod-2^32 sum of the written words.

## Operation
- States: IDLE, LOAD, DRAIN, VERIFY, CHECK, DONE. Reset enters IDLE.
- Reset values:
  - `cpu_resetn`=1; `busy`, `done`, `fifo_rd`=0.
  - `err_code`=0, `words_written`=0, `checksum`=0.
  - Registered loader-side memory signals all 0.
- Port ownership:
  - In IDLE the memory port is combinationally the `cpu_*` inputs.
  - In all other states the loader owns the port and the `cpu_*` inputs are ignored.
- IDLE:
  - On a `prog_en` rising edge, latch `word_count` as N; clear `words_written`, `checksum` and `err_code`; drive `cpu_resetn`=0.
  - If N > `MAX_WORDS`: go to DONE with `err_code`=1; no memory access.
  - If N = 0: go to DONE with `err_code`=0.
  - Otherwise go to LOAD.
- LOAD:
  - `fifo_rd` = !`fifo_empty` && (`words_written` < N).
  - On each pop: register the memory write for the next cycle.
    - `mem_en`=1, `mem_we`=4'hF.
    - `mem_addr` = `BASE_ADDR` + 4·`words_written`; `mem_din` = `fifo_dout`.
  - On each pop: `checksum` += `fifo_dout`, `words_written`++.
  - Back-to-back pops run at 1 word/cycle.
  - Extra FIFO data beyond N is left unread.
  - When the N-th pop occurs, go to DRAIN.
- DRAIN: the final write issues this cycle; then go to VERIFY with read index 0 and readback sum R=0.
- VERIFY:
  - Issue reads with `mem_en`=1, `mem_we`=0, `mem_addr` = `BASE_ADDR` + 4·k, for k = 0..N-1, one per cycle.
  - R += `mem_dout` on the cycle after each read.
  - After the last read issues, go to CHECK.
- CHECK: accumulate the final `mem_dout`. Set `err_code`=2 if R ≠ `checksum`. Go to DONE.
- DONE:
  - `done`=1; `cpu_resetn` stays 0.
  - On `prog_en`=0: go to IDLE, `cpu_resetn`=1 the next cycle, `done`=0.
  - Status outputs hold until the next load.
- Abort: `prog_en`=0 in LOAD, DRAIN, VERIFY or CHECK:
  - Any write registered this cycle still completes.
  - Go to IDLE with `err_code`=3; `cpu_resetn`=1; `words_written` holds its value.
- `RESETn`=0 at any time: IDLE with the reset values, overriding all other events.

## Timing
- `prog_en` edge sampled at cycle 0 → LOAD at cycle 1; `cpu_resetn` falls at cycle 1.
- Pop at cycle c → memory write at cycle c+1.
- Write-to-`done` latency from the last pop: 1 (DRAIN) + N (VERIFY) + 1 (CHECK) → `done` at cycle c_last+N+3.
- Simultaneous `fifo_empty` deassertion and the N-th-word condition: the pop occurs.
- Nothing is popped while `words_written` = N.

## Test plan
- Load of 4 words:
  - Stimulus: N=4, FIFO holds 0x1, 0x2, 0x3, 0xFFFF_FFFF, `BASE_ADDR`=0.
  - Required: writes to 0x0, 0x4, 0x8, 0xC on 4 consecutive cycles; `checksum`=0x0000_0005; `done`=1 at pop+7; `err_code`=0; `cpu_resetn`=1 one cycle after `prog_en`=0.
- Starved FIFO: N=3 with words supplied at cycles 2, 9 and 20 → exactly 3 writes, no spurious pops, `words_written`=3.
- Oversize and zero requests:
  - N=16385 → `done`=1, `err_code`=1, `mem_en` never asserted.
  - N=0 → `done`=1, `err_code`=0.
- Corrupted readback: force `mem_dout` +1 on k=2 during VERIFY → `err_code`=2.
- Abort during LOAD: drop `prog_en` after 2 of 8 words → IDLE, `err_code`=3, `words_written`=2, port handed back to the core.
- IDLE passthrough and reset: `cpu_maddr`=0x40, `cpu_men`=1 → `mem_addr`=0x40 the same cycle; `RESETn`=0 mid-VERIFY → all outputs at reset values the next cycle.
